// File: rtl/fabricport_pkg.sv
// Shared definitions for the fabric-port arbiter: flit bit positions, FSM states,
// and packet-framing helpers. The optional VC remap is enabled by FABRICPORT_ARB_VC_REMAP_EN.
package fabricport_pkg;

    localparam int FLITS_PER_WORD = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Bit offsets inside one flit, counted from the flit LSB.
    function automatic int valid_off(input int w_noc);
        return w_noc - 1;
    endfunction

    function automatic int head_off(input int w_noc);
        return w_noc - 2;
    endfunction

    function automatic int tail_off(input int w_noc);
        return w_noc - 3;
    endfunction

    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    function automatic int vc_msb_off(input int w_noc);
        return w_noc - 4;
    endfunction

    function automatic int vc_lsb_off(input int w_noc, input int num_vc);
        return w_noc - 3 - vc_width(num_vc);
    endfunction

    function automatic int dest_msb_off(input int w_noc, input int num_vc);
        return vc_lsb_off(w_noc, num_vc) - 1;
    endfunction

    function automatic int dest_lsb_off(input int w_noc, input int num_vc, input int n);
        return dest_msb_off(w_noc, num_vc) - $clog2(n) + 1;
    endfunction

    // Flit 0 sits in the most significant slice and is sent first.
    function automatic int flit_lsb(input int w_rtl, input int w_noc, input int j);
        return w_rtl - w_noc * (j + 1);
    endfunction

    function automatic logic last_valid_is_tail(input logic [FLITS_PER_WORD-1:0] v,
                                                input logic [FLITS_PER_WORD-1:0] t);
        logic res;
        res = 1'b0;
        for (int j = 0; j < FLITS_PER_WORD; j++) begin
            if (v[j]) res = t[j];
        end
        return res;
    endfunction

    function automatic logic first_valid_is_head(input logic [FLITS_PER_WORD-1:0] v,
                                                 input logic [FLITS_PER_WORD-1:0] h);
        logic res;
        res = 1'b0;
        for (int j = FLITS_PER_WORD - 1; j >= 0; j--) begin
            if (v[j]) res = h[j];
        end
        return res;
    endfunction

endpackage

// File: rtl/fabricport_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// searching cyclically, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant_oh,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
    output logic                       o_any
);
    import fabricport_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int v_idx;
        logic v_found;
        v_idx       = 0;
        v_found     = 1'b0;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = (int'(i_ptr) + i) % NUM_REQ;
            if (!v_found && i_req[v_idx]) begin
                v_found            = 1'b1;
                o_grant_oh[v_idx]  = 1'b1;
                o_grant_idx        = IDX_W'(v_idx);
            end
        end
        o_any = v_found;
    end

endmodule

// File: rtl/fabricport_arbiter.sv
// Packet-atomic round-robin arbiter sharing one fabric-port injection interface.
// Define FABRICPORT_ARB_VC_REMAP_EN to rewrite each valid flit's VC with grant_id % NUM_VC.
module fabricport_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_NOC = 128,
    parameter int WIDTH_RTL = 512,
    parameter int N         = 16,
    parameter int NUM_VC    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ*WIDTH_RTL-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [WIDTH_RTL-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           err_head
);
    import fabricport_pkg::*;

    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int FPW      = FLITS_PER_WORD;
    localparam int VALID_O  = valid_off(WIDTH_NOC);
    localparam int HEAD_O   = head_off(WIDTH_NOC);
    localparam int TAIL_O   = tail_off(WIDTH_NOC);

    if ((WIDTH_RTL != FPW * WIDTH_NOC) ||
        (WIDTH_NOC < 3 + vc_width(NUM_VC) + $clog2(N))) begin : g_bad_cfg
        $error("fabricport_arbiter: flit fields do not fit the configured widths");
    end

    state_e                 r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_grant_id;
    logic [WIDTH_RTL-1:0]   r_out_data;
    logic                   r_out_valid;
    logic                   r_err_head;
    logic                   r_first;

    logic [NUM_REQ-1:0]     w_pick_oh;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_any;
    logic                   w_can_accept;
    logic                   w_accept;
    logic [WIDTH_RTL-1:0]   w_sel_word;
    logic [WIDTH_RTL-1:0]   w_out_word;
    logic [FPW-1:0]         w_fv;
    logic [FPW-1:0]         w_fh;
    logic [FPW-1:0]         w_ft;
    logic                   w_has_valid;
    logic                   w_is_tail;
    logic                   w_is_head;
    logic [IDX_W-1:0]       w_ptr_next;
    logic [NUM_REQ-1:0]     w_req_ready;

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_rr (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant_oh  (w_pick_oh),
        .o_grant_idx (w_pick_idx),
        .o_any       (w_pick_any)
    );

    assign w_can_accept = !r_out_valid || out_ready;
    assign w_sel_word   = req_data[r_grant_id*WIDTH_RTL +: WIDTH_RTL];
    assign w_accept     = (r_state == LOCKED) && req_valid[r_grant_id] && w_can_accept;

    always_comb begin
        w_fv = '0;
        w_fh = '0;
        w_ft = '0;
        for (int j = 0; j < FPW; j++) begin
            w_fv[j] = w_sel_word[flit_lsb(WIDTH_RTL, WIDTH_NOC, j) + VALID_O];
            w_fh[j] = w_sel_word[flit_lsb(WIDTH_RTL, WIDTH_NOC, j) + HEAD_O];
            w_ft[j] = w_sel_word[flit_lsb(WIDTH_RTL, WIDTH_NOC, j) + TAIL_O];
        end
    end

    assign w_has_valid = |w_fv;
    assign w_is_tail   = last_valid_is_tail(w_fv, w_ft);
    assign w_is_head   = first_valid_is_head(w_fv, w_fh);
    assign w_ptr_next  = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + IDX_W'(1);

`ifdef FABRICPORT_ARB_VC_REMAP_EN
    localparam int VC_W    = vc_width(NUM_VC);
    localparam int VC_LSB  = vc_lsb_off(WIDTH_NOC, NUM_VC);

    // Invalid flits are left untouched so idle slots stay bit-exact.
    always_comb begin
        w_out_word = w_sel_word;
        for (int j = 0; j < FPW; j++) begin
            if (w_fv[j]) begin
                w_out_word[flit_lsb(WIDTH_RTL, WIDTH_NOC, j) + VC_LSB +: VC_W] =
                    VC_W'(int'(r_grant_id) % NUM_VC);
            end
        end
    end
`else
    assign w_out_word = w_sel_word;
`endif

    always_comb begin
        w_req_ready = '0;
        if (r_state == LOCKED) w_req_ready[r_grant_id] = w_can_accept;
    end

    // The first word carrying valid flits after a grant is the one checked for a head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_err_head  <= 1'b0;
            r_first     <= 1'b0;
        end else begin
            if (out_ready) r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant_id <= w_pick_idx;
                        r_first    <= 1'b1;
                        r_state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_accept && w_has_valid) begin
                        r_out_data  <= w_out_word;
                        r_out_valid <= 1'b1;
                        r_first     <= 1'b0;
                        if (r_first && !w_is_head) r_err_head <= 1'b1;
                        if (w_is_tail) begin
                            r_ptr   <= w_ptr_next;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state == LOCKED);
    assign err_head  = r_err_head;

endmodule

// File: doc/fabricport_arbiter.md
Name: fabricport_arbiter

Overview:
- Shares one fabric-port injection interface (WIDTH_RTL word = 4 NoC flits, valid/ready) between NUM_REQ requester modules on the same clock.
- Round-robin, packet-atomic: a grant is held from the word with the first head flit until the word whose last valid flit has its tail bit set.
- Output is registered and drives the fabric interface's per-node input side (packets / valid / ready).

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH_NOC, 128, flit width.
- WIDTH_RTL, 512, word width; must equal 4*WIDTH_NOC.
- N, 16, NoC node count; destination field is $clog2(N) bits.
- NUM_VC, 2, VC count; VC field is $clog2(NUM_VC) bits.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- req_data  in  [WIDTH_RTL-1:0] x NUM_REQ  requester words.
- req_valid  in  1 x NUM_REQ  requester word valid.
- req_ready  out  1 x NUM_REQ  word accepted when valid&ready.
- out_data  out  WIDTH_RTL  word to fabric port.
- out_valid  out  1  out_data valid.
- out_ready  in  1  fabric port ready.
- grant_id  out  $clog2(NUM_REQ)  current owner.
- busy  out  1  grant held (LOCKED).
- err_head  out  1  sticky protocol error.

Behaviour:
- Flit layout:
  - Flit j (j=0..3) occupies [WIDTH_RTL-1-WIDTH_NOC*j -: WIDTH_NOC]; flit 0 is sent first.
  - Within a flit: valid=WIDTH_NOC-1, head=WIDTH_NOC-2, tail=WIDTH_NOC-3, VC field starts at WIDTH_NOC-4 (downward), dest field below it.
- Reset (rst=0, async):
  - out_valid=0, out_data=0, req_ready=0, busy=0, grant_id=0, err_head=0.
  - Round-robin pointer=0; state=IDLE.
  - A partially sent packet is abandoned; requesters must re-send it from the head.
- can_accept = !out_valid | out_ready.
- State IDLE:
  - req_ready all 0.
  - If any req_valid: winner = first asserted index at or after the pointer (cyclic); latch grant_id; go to LOCKED.
  - Arbitration costs 1 cycle.
- State LOCKED:
  - req_ready[grant_id] = can_accept; all others 0.
  - On accept, a word with >=1 valid flit loads out_data/out_valid=1 on the next edge.
  - A word with zero valid flits is consumed, dropped and produces no output.
- Release:
  - If the last valid flit of the accepted word has tail=1, go to IDLE and set pointer = grant_id+1 (wraps at NUM_REQ).
  - A tail followed by a head within one word keeps the grant.
- Error check:
  - The first accepted word after each grant must have head=1 on its first valid flit; otherwise err_head is set.
  - The word is still forwarded. err_head clears only on reset.
- Output register: holds while out_valid & !out_ready; out_valid drops on out_ready when no new word is accepted.
- Minimum latency:
  - req_valid to out_valid: 2 cycles.
  - Back-to-back packets from different requesters: 1 idle bubble cycle.
- Simultaneous events:
  - A tail word and a new req_valid in the same cycle: the new request is arbitrated in the next (IDLE) cycle.
  - Requester deasserting valid mid-packet: the grant is held indefinitely (no timeout).

Optional Feature:
- Macro FABRICPORT_ARB_VC_REMAP_EN.
- When defined: every valid flit's VC field is overwritten with grant_id % NUM_VC as it is loaded into the output register; all other bits are unchanged.
- When undefined: words pass through bit-exact.

Decomposition:
- Package fabricport_pkg:
  - Flit position constants (VALID/HEAD/TAIL/VC/DEST offsets as functions of WIDTH_NOC, NUM_VC).
  - Flits-per-word constant 4.
  - State enum {IDLE, LOCKED}.
  - Helper functions last_valid_is_tail() and first_valid_is_head().
- Sub-module rr_arbiter: combinational round-robin pick from a request vector and a pointer, plus a one-hot/index grant output.

Test Plan:
- Single packet: req0 sends a 2-word packet with 8 valid flits (head in flit 0 of word 1, tail in flit 3 of word 2), out_ready=1 -> out_valid at cycles 2 and 3 carries identical words; busy deasserts after word 2; grant_id=0.
- Contention: req1 and req3 both valid with 1-word packets, pointer=0 -> req1 served, 1 bubble, then req3; pointer ends at 0 (wrapped from 3+1).
- Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data stable, req_ready=0, no word lost or duplicated; flow resumes on out_ready=1.
- Boundaries:
  - An all-invalid word is consumed with no output.
  - A word with tail in flit 1 and head in flit 2 keeps the grant.
  - The first word lacking head sets err_head=1 and the word is still output.
- Reset mid-packet: rst low while LOCKED with out_valid=1 -> all outputs 0 immediately; after release, a new request is arbitrated from pointer 0.
- With FABRICPORT_ARB_VC_REMAP_EN: req3 sends flits with VC=0, NUM_VC=2 -> output flits carry VC=1, all other bits equal.
